// File: rtl/pipe_fifo.sv
// N-entry pipeline buffer: valid/ready on the write side, valid/yumi on the read side.
// All outputs come from registered state; flush and reset clear pointers and count only.
module pipe_fifo #(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = DEPTH - 1,
  localparam int CW       = $clog2(DEPTH + 1),
  localparam int PW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             processed,
  input  logic             flush_i,
  output logic [CW-1:0]    count_o,
  output logic             almost_full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  assign ready_o       = (count_q != CW'(DEPTH));
  assign valid_o       = (count_q != '0);
  assign data_o        = valid_o ? mem_q[rd_q] : '0;
  assign count_o       = count_q;
  assign almost_full_o = (count_q >= CW'(AF_THRESH));

  // ready_o ignores processed, so a full buffer never takes a word even while draining
  assign push = valid_i & ready_o;
  assign pop  = processed & valid_o;

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (push) wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
    if (pop)  rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (flush_i) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; a stale entry is never visible because data_o is gated by count.
  always_ff @(posedge clk) begin
    if (push && !flush_i && !rst) mem_q[wr_q] <= data_i;
  end

endmodule

// File: tb/tb_pipe_fifo.sv
// Self-checking bench for pipe_fifo: queue scoreboard on every cycle plus directed checks.
module tb_pipe_fifo;
  localparam int WIDTH = 64;
  localparam int DEPTH = 4;
  localparam int AF    = DEPTH - 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] data_i = '0;
  logic             valid_i = 1'b0;
  logic             ready_o;
  logic             valid_o;
  logic [WIDTH-1:0] data_o;
  logic             processed = 1'b0;
  logic             flush_i = 1'b0;
  logic [CW-1:0]    count_o;
  logic             almost_full_o;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;
  logic [WIDTH-1:0] sb [$];

  pipe_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .valid_o(valid_o), .data_o(data_o), .processed(processed), .flush_i(flush_i),
    .count_o(count_o), .almost_full_o(almost_full_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic [63:0] d, input logic p, input logic f);
    valid_i = v; data_i = d; processed = p; flush_i = f;
    @(posedge clk); #1;
    valid_i = 1'b0; processed = 1'b0; flush_i = 1'b0;
  endtask

  // Scoreboard: compare state against the queue, then apply this cycle's handshakes.
  always @(negedge clk) begin
    if (mon_en) begin
      int  n;
      bit  do_pop, do_push;
      n = sb.size();
      chk("sb_count", 64'(count_o), 64'(n));
      chk("sb_valid", 64'(valid_o), 64'(n != 0));
      chk("sb_ready", 64'(ready_o), 64'(n != DEPTH));
      chk("sb_af",    64'(almost_full_o), 64'(n >= AF));
      chk("sb_data",  data_o, (n != 0) ? sb[0] : 64'h0);
      do_pop  = processed && (n != 0);
      do_push = valid_i && (n != DEPTH);
      if (rst || flush_i) sb.delete();
      else begin
        if (do_pop)  void'(sb.pop_front());
        if (do_push) sb.push_back(data_i);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int nin, nout, cyc;
    // 1: reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", 64'(valid_o), 64'h0);
    chk("rst_ready", 64'(ready_o), 64'h1);
    chk("rst_count", 64'(count_o), 64'h0);
    chk("rst_data",  data_o, 64'h0);
    chk("rst_af",    64'(almost_full_o), 64'h0);
    mon_en = 1'b1;

    // 2: single word, held while not processed
    step(1'b1, 64'h600d600d, 1'b0, 1'b0);
    chk("one_valid", 64'(valid_o), 64'h1);
    chk("one_count", 64'(count_o), 64'h1);
    for (int i = 0; i < 5; i++) begin
      chk("one_hold", data_o, 64'h600d600d);
      step(1'b0, 64'h0, 1'b0, 1'b0);
    end
    step(1'b0, 64'h0, 1'b1, 1'b0);
    chk("one_empty", 64'(valid_o), 64'h0);

    // 3: fill, overflow attempt, drain
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 64'(i), 1'b0, 1'b0);
      if (i == 3) chk("fill_af", 64'(almost_full_o), 64'h1);
    end
    chk("full_ready", 64'(ready_o), 64'h0);
    chk("full_count", 64'(count_o), 64'h4);
    step(1'b1, 64'h5, 1'b0, 1'b0);
    chk("ovf_count", 64'(count_o), 64'h4);
    step(1'b1, 64'h5, 1'b1, 1'b0);   // full + processed: pop only
    chk("fullpop_count", 64'(count_o), 64'h3);
    for (int i = 2; i <= 4; i++) begin
      chk("drain_data", data_o, 64'(i));
      step(1'b0, 64'h0, 1'b1, 1'b0);
    end
    chk("drain_empty", 64'(valid_o), 64'h0);

    // 4: simultaneous push/pop
    step(1'b1, 64'h21, 1'b0, 1'b0);
    step(1'b1, 64'h22, 1'b0, 1'b0);
    step(1'b1, 64'habcdabcd, 1'b1, 1'b0);
    chk("pp_count", 64'(count_o), 64'h2);
    chk("pp_head",  data_o, 64'h22);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    chk("pp_third", data_o, 64'habcdabcd);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0);   // processed while empty
    chk("yumi_empty_cnt", 64'(count_o), 64'h0);
    chk("yumi_empty_vld", 64'(valid_o), 64'h0);

    // 5: stream 'h10..'h19 with random back-pressure
    nin = 0; nout = 0; cyc = 0;
    while ((nout < 10) && (cyc < 300)) begin
      logic p, v;
      p = 1'($urandom_range(0, 1));
      v = (nin < 10);
      if (p && valid_o) begin
        chk("stream_order", data_o, 64'(16 + nout));
        nout++;
      end
      if (v && ready_o) nin++;
      step(v, 64'(16 + (v && !ready_o ? nin : (v ? nin - 1 : 0))), p, 1'b0);
      cyc++;
    end
    chk("stream_done", 64'(nout), 64'd10);

    // 6: flush with a push offered, then reset mid-stream
    for (int i = 0; i < 3; i++) step(1'b1, 64'(8'h70 + i), 1'b0, 1'b0);
    chk("pre_flush_cnt", 64'(count_o), 64'h3);
    step(1'b1, 64'h99, 1'b1, 1'b1);
    chk("flush_count", 64'(count_o), 64'h0);
    chk("flush_valid", 64'(valid_o), 64'h0);
    chk("flush_ready", 64'(ready_o), 64'h1);
    chk("flush_data",  data_o, 64'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 64'(8'h80 + i), 1'b0, 1'b0);
    chk("pre_rst_cnt", 64'(count_o), 64'h3);
    rst = 1'b1;
    step(1'b1, 64'h98, 1'b1, 1'b0);
    rst = 1'b0;
    chk("mrst_count", 64'(count_o), 64'h0);
    chk("mrst_valid", 64'(valid_o), 64'h0);
    chk("mrst_ready", 64'(ready_o), 64'h1);
    chk("mrst_data",  data_o, 64'h0);
    step(1'b1, 64'h1234, 1'b0, 1'b0);
    chk("post_rst_data", data_o, 64'h1234);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    step(1'b0, 64'h0, 1'b0, 1'b0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
